// File: rtl/fixed_point_mac_pipe.sv
// fixed_point_mac_pipe: pipelined signed Q-format multiply-accumulate.
//   S1 registers the operands, S2 the full 2N-bit product, S3 the running
//   sum (and the closed sum on a last beat). The output register then loads
//   the rounded and saturated (N,Q) result.
// Build option: define FXP_MAC_ROUND_EN for round-half-up. Left undefined,
// the result is truncated toward -inf with a plain arithmetic shift.
module fixed_point_mac_pipe #(
  parameter int N         = 16,
  parameter int Q         = 12,
  parameter int ACC_GUARD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_acc,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_overflow
);

  localparam int AW = 2*N + ACC_GUARD;  // accumulator width
  localparam int RW = AW + 1;           // one extra bit so rounding cannot wrap

`ifdef FXP_MAC_ROUND_EN
  localparam logic [RW-1:0] RND = RW'(1) << (Q-1);
`else
  localparam logic [RW-1:0] RND = '0;
`endif

  localparam logic signed [RW-1:0] MAXV = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};

  // The whole pipe advances only when the output register is free.
  logic w_en;
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  // Stage 1 registers
  logic         r_s1_valid;
  logic         r_s1_acc;
  logic         r_s1_last;
  logic [N-1:0] r_s1_a;
  logic [N-1:0] r_s1_b;

  // Stage 2 registers
  logic                  r_s2_valid;
  logic                  r_s2_acc;
  logic                  r_s2_last;
  logic signed [2*N-1:0] r_s2_prod;

  // Stage 3 registers
  logic                 r_s3_valid;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] r_s3_sum;

  logic signed [2*N-1:0] w_prod;
  logic signed [AW-1:0]  w_prod_ext;
  logic signed [AW-1:0]  w_sum;
  logic signed [RW-1:0]  w_rnd;
  logic signed [RW-1:0]  w_shift;
  logic [N-1:0]          w_res;
  logic                  w_ovf;

  assign w_prod     = $signed(r_s1_a) * $signed(r_s1_b);
  assign w_prod_ext = {{ACC_GUARD{r_s2_prod[2*N-1]}}, r_s2_prod};
  assign w_sum      = r_s2_acc ? (r_acc + w_prod_ext) : w_prod_ext;
  assign w_rnd      = $signed({r_s3_sum[AW-1], r_s3_sum}) + $signed(RND);
  assign w_shift    = w_rnd >>> Q;

  // S1: capture the accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_acc   <= in_acc;
      r_s1_last  <= in_last;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end
  end

  // S2: register the full-precision signed product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_acc   <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_acc   <= r_s1_acc;
      r_s2_last  <= r_s1_last;
      r_s2_prod  <= w_prod;
    end
  end

  // S3: update the running sum; a last beat parks the closed sum in r_s3_sum
  // and clears the accumulator so the next beat always starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_acc      <= '0;
      r_s3_sum   <= '0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        if (r_s2_last) begin
          r_acc    <= '0;
          r_s3_sum <= w_sum;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // Saturate the rounded, shifted sum back into (N,Q)
  always_comb begin
    w_res = w_shift[N-1:0];
    w_ovf = 1'b0;
    if (w_shift > MAXV) begin
      w_res = MAXV[N-1:0];
      w_ovf = 1'b1;
    end else if (w_shift < MINV) begin
      w_res = MINV[N-1:0];
      w_ovf = 1'b1;
    end
  end

  // Output register: load on a closed sum, drop valid once taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else if (w_en && r_s3_valid) begin
      out_valid    <= 1'b1;
      out_result   <= w_res;
      out_overflow <= w_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_point_mac_pipe.sv
// Directed bench for fixed_point_mac_pipe at N=16, Q=12, ACC_GUARD=4.
module tb_fixed_point_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_acc;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] q_res[$];
  logic        q_ovf[$];

  fixed_point_mac_pipe #(.N(16), .Q(12), .ACC_GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Record every completed output handshake; inputs only change at negedge,
  // so values seen here hold through the following rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      q_res.push_back(out_result);
      q_ovf.push_back(out_overflow);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic acc, input logic last);
    int guard = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_acc = acc; in_last = last; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit timed_out);
    int guard = 0;
    while (q_res.size() < n && guard < 60) begin
      @(negedge clk); guard++;
    end
    repeat (6) @(negedge clk);
    timed_out = (q_res.size() < n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    n_total++;
    if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_overflow !== 1'b0)
      $display("FAIL reset_outputs: valid=%0b result=%h ovf=%0b required 0/0000/0",
               out_valid, out_result, out_overflow);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int  n = 0;
    bit  to;
    q_res.delete(); q_ovf.delete();
    send(16'h1800, 16'h2000, 1'b0, 1'b1);
    while (n < 10) begin
      @(negedge clk); n++;
      if (out_valid) break;
    end
    n_total++;
    if (n !== 4) $display("FAIL single_latency: out_valid after %0d edges, required 3 after accept", n - 1);
    else n_pass++;
    send(16'hE800, 16'h2000, 1'b0, 1'b1);
    wait_results(2, to);
    n_total++;
    if (to || q_res.size() != 2) $display("FAIL single_count: got %0d results required 2", q_res.size());
    else n_pass++;
    if (q_res.size() == 2) begin
      n_total++;
      if (q_res[0] !== 16'h3000 || q_ovf[0] !== 1'b0)
        $display("FAIL single_pos: got %h/%0b required 3000/0", q_res[0], q_ovf[0]);
      else n_pass++;
      n_total++;
      if (q_res[1] !== 16'hD000 || q_ovf[1] !== 1'b0)
        $display("FAIL single_neg: got %h/%0b required d000/0", q_res[1], q_ovf[1]);
      else n_pass++;
    end
  endtask

  task automatic test_extremes;
    logic [15:0] exp_r[3] = '{16'h8000, 16'h7FFF, 16'h7FFF};
    logic        exp_o[3] = '{1'b0, 1'b1, 1'b1};
    bit to;
    q_res.delete(); q_ovf.delete();
    send(16'h8000, 16'h1000, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b1);
    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    wait_results(3, to);
    n_total++;
    if (to || q_res.size() != 3) $display("FAIL extremes_count: got %0d required 3", q_res.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i < q_res.size()) begin
        n_total++;
        if (q_res[i] !== exp_r[i] || q_ovf[i] !== exp_o[i])
          $display("FAIL extremes_%0d: got %h/%0b required %h/%0b",
                   i, q_res[i], q_ovf[i], exp_r[i], exp_o[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    q_res.delete(); q_ovf.delete();
    send(16'h1000, 16'h1000, 1'b0, 1'b0);
    send(16'h1000, 16'h1000, 1'b1, 1'b0);
    send(16'h1000, 16'h1000, 1'b1, 1'b1);
    send(16'h1000, 16'h2000, 1'b1, 1'b1);
    wait_results(2, to);
    n_total++;
    if (to || q_res.size() != 2) $display("FAIL accum_count: got %0d required 2", q_res.size());
    else n_pass++;
    if (q_res.size() >= 2) begin
      n_total++;
      if (q_res[0] !== 16'h3000 || q_ovf[0] !== 1'b0)
        $display("FAIL accum_sum: got %h/%0b required 3000/0", q_res[0], q_ovf[0]);
      else n_pass++;
      n_total++;
      if (q_res[1] !== 16'h2000 || q_ovf[1] !== 1'b0)
        $display("FAIL accum_cleared: got %h/%0b required 2000/0", q_res[1], q_ovf[1]);
      else n_pass++;
    end
  endtask

  task automatic test_rounding;
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
    bit to;
`ifdef FXP_MAC_ROUND_EN
    exp_pos = 16'h0001; exp_neg = 16'h0000;
`else
    exp_pos = 16'h0000; exp_neg = 16'hFFFF;
`endif
    q_res.delete(); q_ovf.delete();
    send(16'h0001, 16'h0800, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0800, 1'b0, 1'b1);
    wait_results(2, to);
    n_total++;
    if (to || q_res.size() != 2) $display("FAIL round_count: got %0d required 2", q_res.size());
    else n_pass++;
    if (q_res.size() >= 2) begin
      n_total++;
      if (q_res[0] !== exp_pos) $display("FAIL round_pos: got %h required %h", q_res[0], exp_pos);
      else n_pass++;
      n_total++;
      if (q_res[1] !== exp_neg) $display("FAIL round_neg: got %h required %h", q_res[1], exp_neg);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp_r[4] = '{16'h1000, 16'h2000, 16'h4000, 16'h3000};
    bit to;
    q_res.delete(); q_ovf.delete();
    @(negedge clk); out_ready = 1'b0;
    send(16'h1000, 16'h1000, 1'b0, 1'b1);
    send(16'h1000, 16'h2000, 1'b0, 1'b1);
    send(16'h2000, 16'h2000, 1'b0, 1'b1);
    send(16'h3000, 16'h1000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL bp_stall: valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
    else n_pass++;
    n_total++;
    if (out_result !== 16'h1000) $display("FAIL bp_head: got %h required 1000", out_result);
    else n_pass++;
    repeat (4) @(negedge clk);
    #1;
    n_total++;
    if (out_result !== 16'h1000 || out_valid !== 1'b1)
      $display("FAIL bp_stable: got %h/%0b required 1000/1", out_result, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    wait_results(4, to);
    n_total++;
    if (to || q_res.size() != 4) $display("FAIL bp_count: got %0d required 4", q_res.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < q_res.size()) begin
        n_total++;
        if (q_res[i] !== exp_r[i]) $display("FAIL bp_order_%0d: got %h required %h", i, q_res[i], exp_r[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_sum;
    bit to;
    q_res.delete(); q_ovf.delete();
    send(16'h1000, 16'h1000, 1'b0, 1'b0);
    send(16'h1000, 16'h1000, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_overflow !== 1'b0)
      $display("FAIL midreset_outputs: valid=%0b result=%h ovf=%0b required 0/0000/0",
               out_valid, out_result, out_overflow);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    send(16'h1000, 16'h1000, 1'b1, 1'b1);
    wait_results(1, to);
    n_total++;
    if (to || q_res.size() != 1) $display("FAIL midreset_count: got %0d required 1", q_res.size());
    else n_pass++;
    if (q_res.size() >= 1) begin
      n_total++;
      if (q_res[0] !== 16'h1000) $display("FAIL midreset_fresh: got %h required 1000", q_res[0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_rounding();
    test_backpressure();
    test_reset_mid_sum();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
